// File: rtl/serial_tx_piso.sv
// serial_tx_piso: parallel-in, serial-out frame transmitter.
// Frame on tx_out, LSB first: start(0), DATA_W data bits, [parity], stop(1).
// Each bit is held for CLKS_PER_BIT clocks.
// Optional even parity bit: define SERIAL_TX_PARITY_EN.
module serial_tx_piso #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cyc_q, cyc_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
`ifdef SERIAL_TX_PARITY_EN
    logic                par_q, par_d;
`endif
    logic                out_q, out_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                bit_end;
    logic                accept;

    assign bit_end  = (cyc_q == CYC_LAST);
    assign accept   = tx_valid && (state_q == IDLE);
    assign tx_ready = (state_q == IDLE);
    assign tx_out   = out_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state, bit timing and shift register update
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef SERIAL_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != IDLE) begin
            cyc_d = bit_end ? '0 : cyc_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                cyc_d = '0;
                if (accept) begin
                    state_d = START;
                    shift_d = tx_data;
                    bit_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
                    par_d   = ^tx_data;
`endif
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered line changes on the same edge
    always_comb begin
        out_d  = 1'b1;
        busy_d = (state_d != IDLE);
        done_d = (state_q == STOP) && (state_d == IDLE);
        case (state_d)
            IDLE:   out_d = 1'b1;
            START:  out_d = 1'b0;
            DATA:   out_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
            PARITY: out_d = par_d;
`endif
            STOP:   out_d = 1'b1;
            default: out_d = 1'b1;
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

endmodule
